ami_req_queue: RTL

- Input queue for AMIRequests, sitting directly upstream of the block buffer; its head output drives the block buffer's request-queue input.
- Accepts packed AMIRequest words from the memory-interface side.
- Stores them in a first-word-fall-through FIFO.
- Presents the oldest request, plus its pre-decoded sector index (addr[5:3]), to the block buffer FSM, which dequeues explicitly.

---
 rtl/ami_types_pkg.sv | 28 ++
 rtl/ami_req_queue_mem.sv | 26 ++
 rtl/ami_req_queue.sv | 83 ++++++++
 3 files changed

// File: rtl/ami_types_pkg.sv
// AMIRequest bus layout shared by the request queue and the block buffer.
package ami_types_pkg;

  localparam int AMI_ADDR_WIDTH        = 64;
  localparam int AMI_DATA_WIDTH        = 576;
  localparam int AMI_REQ_SIZE_WIDTH    = 6;
  localparam int AMI_REQUEST_BUS_WIDTH = 648;

  localparam int REQ_VALID_BIT    = 0;
  localparam int REQ_IS_WRITE_BIT = 1;
  localparam int REQ_ADDR_LSB     = 2;
  localparam int REQ_ADDR_MSB     = 65;
  localparam int REQ_DATA_LSB     = 66;
  localparam int REQ_DATA_MSB     = 641;
  localparam int REQ_SIZE_LSB     = 642;
  localparam int REQ_SIZE_MSB     = 647;

  localparam int SECTOR_IDX_LSB = 3;
  localparam int SECTOR_IDX_W   = 3;

  typedef logic [AMI_REQUEST_BUS_WIDTH-1:0] ami_req_t;

  // Sector index is addr[5:3], i.e. bus bits 7:5.
  function automatic logic [SECTOR_IDX_W-1:0] req_sector_idx(input ami_req_t req);
    return req[REQ_ADDR_LSB+SECTOR_IDX_LSB +: SECTOR_IDX_W];
  endfunction

endpackage

// File: rtl/ami_req_queue_mem.sv
// Request storage: registered write port, combinational read port (FWFT head).
module ami_req_queue_mem
  import ami_types_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  ami_req_t         wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output ami_req_t         rd_data
);

  ami_req_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ami_req_queue.sv
// FWFT input queue of AMIRequests feeding the block buffer.
// Optional drop counter enabled by defining AMI_REQ_QUEUE_DROP_CNT_EN.
module ami_req_queue
  import ami_types_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  ami_req_t                enq_req,
  output logic                    enq_ready,
  input  logic                    deq_en,
`ifdef AMI_REQ_QUEUE_DROP_CNT_EN
  input  logic                    drop_cnt_clr,
  output logic [15:0]             drop_cnt,
`endif
  output ami_req_t                head_req,
  output logic [SECTOR_IDX_W-1:0] head_sector_idx,
  output logic                    empty,
  output logic                    full,
  output logic [PTR_W:0]          count
);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push;
  logic             pop;
  ami_req_t         mem_rd_data;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign enq_ready = ~full;
  assign count     = count_reg;

  // Decided from registered occupancy only, so a pop never opens room for a same-cycle push.
  assign push = enq_req[REQ_VALID_BIT] & ~full;
  assign pop  = deq_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  ami_req_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push & ~rst),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (enq_req),
    .rd_ptr  (rd_ptr_reg),
    .rd_data (mem_rd_data)
  );

  // Gate the head so an empty queue presents valid=0 instead of stale storage.
  assign head_req        = empty ? '0 : mem_rd_data;
  assign head_sector_idx = req_sector_idx(head_req);

`ifdef AMI_REQ_QUEUE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || drop_cnt_clr) begin
      drop_cnt <= '0;
    end else if (enq_req[REQ_VALID_BIT] && full && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
